// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed display scanner feeding a 7-segment decoder.
// Outputs are registered from next-state decode; value updates apply only at frame boundaries.
module seg_scan_mux #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_mask,
    input  logic        lzb,
    output logic [3:0]  d,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick
);

    localparam int              PW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0]   BLANK_P  = PW'(BLANK);

    logic [PW-1:0] r_pre;
    logic [1:0]    r_idx;
    logic [15:0]   r_act_val;
    logic [3:0]    r_act_dp;
    logic [15:0]   r_pend_val;
    logic [3:0]    r_pend_dp;
    logic          r_pend_v;

    logic          w_slot_end;
    logic          w_boundary;
    logic [PW-1:0] w_pre_nx;
    logic [1:0]    w_idx_nx;
    logic [15:0]   w_act_val_nx;
    logic [3:0]    w_act_dp_nx;
    logic [15:0]   w_pend_val_nx;
    logic [3:0]    w_pend_dp_nx;
    logic          w_pend_v_nx;
    logic          w_sup;
    logic          w_lit;
    logic [3:0]    w_an_nx;

    // Scan counters: prescaler wraps every DIV cycles and advances the digit index.
    always_comb begin
        w_slot_end = (r_pre == PRE_LAST);
        w_boundary = w_slot_end && (r_idx == 2'd3);
        w_pre_nx   = w_slot_end ? '0 : r_pre + PW'(1);
        w_idx_nx   = w_slot_end ? r_idx + 2'd1 : r_idx;
    end

    // A load landing exactly on the boundary bypasses the pending registers.
    always_comb begin
        w_act_val_nx  = r_act_val;
        w_act_dp_nx   = r_act_dp;
        w_pend_val_nx = r_pend_val;
        w_pend_dp_nx  = r_pend_dp;
        w_pend_v_nx   = r_pend_v;
        if (w_boundary) begin
            if (load) begin
                w_act_val_nx = value;
                w_act_dp_nx  = dp_mask;
                w_pend_v_nx  = 1'b0;
            end else if (r_pend_v) begin
                w_act_val_nx = r_pend_val;
                w_act_dp_nx  = r_pend_dp;
                w_pend_v_nx  = 1'b0;
            end
        end else if (load) begin
            w_pend_val_nx = value;
            w_pend_dp_nx  = dp_mask;
            w_pend_v_nx   = 1'b1;
        end
    end

    // Leading-zero suppression: digit idx is dark when it and every higher nibble are zero.
    always_comb begin
        w_sup = 1'b0;
        unique case (w_idx_nx)
            2'd0: w_sup = 1'b0;
            2'd1: w_sup = lzb && (w_act_val_nx[15:4] == 12'd0);
            2'd2: w_sup = lzb && (w_act_val_nx[15:8] == 8'd0);
            2'd3: w_sup = lzb && (w_act_val_nx[15:12] == 4'd0);
            default: w_sup = 1'b0;
        endcase
        w_lit   = (w_pre_nx >= BLANK_P) && !w_sup;
        w_an_nx = w_lit ? ~(4'b0001 << w_idx_nx) : 4'b1111;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre      <= '0;
            r_idx      <= 2'd0;
            r_act_val  <= 16'd0;
            r_act_dp   <= 4'd0;
            r_pend_val <= 16'd0;
            r_pend_dp  <= 4'd0;
            r_pend_v   <= 1'b0;
            d          <= 4'd0;
            an         <= 4'b1111;
            dp         <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            r_pre      <= w_pre_nx;
            r_idx      <= w_idx_nx;
            r_act_val  <= w_act_val_nx;
            r_act_dp   <= w_act_dp_nx;
            r_pend_val <= w_pend_val_nx;
            r_pend_dp  <= w_pend_dp_nx;
            r_pend_v   <= w_pend_v_nx;
            d          <= w_act_val_nx[{w_idx_nx, 2'b00} +: 4];
            an         <= w_an_nx;
            dp         <= w_lit & w_act_dp_nx[w_idx_nx];
            frame_tick <= w_boundary;
        end
    end

endmodule
